// File: rtl/shift_reg_frame.sv
// Universal shift register: deserialises serial bits into framed words, serialises loaded words.
// One-cycle latency on all registered outputs; no backpressure, the mode input is acted on every cycle.
module shift_reg_frame #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [1:0]                 mode,
   input  logic                       data_in,
   input  logic [WIDTH-1:0]           par_in,
   output logic [WIDTH-1:0]           data_out,
   output logic [WIDTH-1:0]           word_out,
   output logic                       word_valid,
   output logic                       serial_out,
   output logic                       tx_done,
   output logic [$clog2(WIDTH)-1:0]   bit_cnt
);

   localparam int CW = $clog2(WIDTH);
   localparam int TW = $clog2(WIDTH + 1);

   localparam logic [1:0] MODE_HOLD      = 2'b00;
   localparam logic [1:0] MODE_SHIFT_IN  = 2'b01;
   localparam logic [1:0] MODE_LOAD      = 2'b10;
   localparam logic [1:0] MODE_SHIFT_OUT = 2'b11;

   logic [TW-1:0]    tx_cnt;
   logic             fill;
   logic [WIDTH-1:0] shifted;

   // Shift-in and shift-out move the same direction; only the fill bit differs.
   always_comb begin
      fill    = (mode == MODE_SHIFT_IN) ? data_in : 1'b0;
      shifted = MSB_FIRST ? {data_out[WIDTH-2:0], fill} : {fill, data_out[WIDTH-1:1]};
   end

   assign serial_out = MSB_FIRST ? data_out[WIDTH-1] : data_out[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out   <= '0;
         word_out   <= '0;
         word_valid <= 1'b0;
         tx_done    <= 1'b0;
         bit_cnt    <= '0;
         tx_cnt     <= '0;
      end else begin
         word_valid <= 1'b0;
         tx_done    <= 1'b0;
         case (mode)
            MODE_SHIFT_IN: begin
               data_out <= shifted;
               if (bit_cnt == CW'(WIDTH - 1)) begin
                  word_out   <= shifted;
                  word_valid <= 1'b1;
                  bit_cnt    <= '0;
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            MODE_LOAD: begin
               data_out <= par_in;
               bit_cnt  <= '0;
               tx_cnt   <= TW'(WIDTH);
            end
            MODE_SHIFT_OUT: begin
               data_out <= shifted;
               bit_cnt  <= '0;
               // Once the loaded word is drained, keep shifting zeros silently.
               if (tx_cnt != '0) begin
                  tx_cnt <= tx_cnt - TW'(1);
                  if (tx_cnt == TW'(1)) tx_done <= 1'b1;
               end
            end
            default: ;  // MODE_HOLD: pause the frame in place
         endcase
      end
   end

endmodule

// File: tb/tb_shift_reg_frame.sv
// Bench for shift_reg_frame: MSB-first and LSB-first instances share stimulus and a bit-level reference model.
module tb_shift_reg_frame;
   localparam int W    = 4;
   localparam int MASK = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   mode;
   logic         data_in;
   logic [W-1:0] par_in;

   logic [W-1:0] m_data, m_word, l_data, l_word;
   logic         m_wv, m_so, m_td, l_wv, l_so, l_td;
   logic [1:0]   m_bc, l_bc;

   int errors = 0;
   int checks = 0;

   // Reference state: index 0 = MSB-first instance, index 1 = LSB-first instance
   int md[2];
   int mw[2];
   int mwv, mtd, tx_left;
   int frame[$];

   always #5 clk = ~clk;

   shift_reg_frame #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .mode(mode), .data_in(data_in), .par_in(par_in),
      .data_out(m_data), .word_out(m_word), .word_valid(m_wv), .serial_out(m_so),
      .tx_done(m_td), .bit_cnt(m_bc));

   shift_reg_frame #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .mode(mode), .data_in(data_in), .par_in(par_in),
      .data_out(l_data), .word_out(l_word), .word_valid(l_wv), .serial_out(l_so),
      .tx_done(l_td), .bit_cnt(l_bc));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Frame semantics: bits are collected in arrival order and the word assembled
   // by position, not by mimicking the register's shift.
   task automatic model_step(input logic r, input logic [1:0] m, input logic d, input logic [W-1:0] p);
      int b;
      b = int'(d);
      if (r) begin
         md[0] = 0; md[1] = 0; mw[0] = 0; mw[1] = 0;
         mwv = 0; mtd = 0; tx_left = 0;
         frame.delete();
      end else begin
         mwv = 0;
         mtd = 0;
         case (m)
            2'b01: begin
               md[0] = ((md[0] << 1) | b) & MASK;
               md[1] = (md[1] >> 1) | (b << (W - 1));
               frame.push_back(b);
               if (frame.size() == W) begin
                  mw[0] = 0;
                  mw[1] = 0;
                  foreach (frame[i]) begin
                     mw[0] += frame[i] << (W - 1 - i);
                     mw[1] += frame[i] << i;
                  end
                  mwv = 1;
                  frame.delete();
               end
            end
            2'b10: begin
               md[0] = int'(p);
               md[1] = int'(p);
               frame.delete();
               tx_left = W;
            end
            2'b11: begin
               md[0] = (md[0] << 1) & MASK;
               md[1] = md[1] >> 1;
               frame.delete();
               if (tx_left > 0) begin
                  tx_left--;
                  if (tx_left == 0) mtd = 1;
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic check_all();
      chk("msb.data_out",   32'(m_data), md[0]);
      chk("msb.word_out",   32'(m_word), mw[0]);
      chk("msb.word_valid", 32'(m_wv),   mwv);
      chk("msb.tx_done",    32'(m_td),   mtd);
      chk("msb.bit_cnt",    32'(m_bc),   frame.size());
      chk("msb.serial_out", 32'(m_so),   (md[0] >> (W - 1)) & 1);
      chk("lsb.data_out",   32'(l_data), md[1]);
      chk("lsb.word_out",   32'(l_word), mw[1]);
      chk("lsb.word_valid", 32'(l_wv),   mwv);
      chk("lsb.tx_done",    32'(l_td),   mtd);
      chk("lsb.bit_cnt",    32'(l_bc),   frame.size());
      chk("lsb.serial_out", 32'(l_so),   md[1] & 1);
   endtask

   task automatic cyc(input logic r, input logic [1:0] m, input logic d, input logic [W-1:0] p);
      rst = r; mode = m; data_in = d; par_in = p;
      @(posedge clk);
      model_step(r, m, d, p);
      #1;
      check_all();
   endtask

   initial begin
      logic [W-1:0] pr;
      rst = 1'b1; mode = 2'b00; data_in = 1'b0; par_in = '0;
      md[0] = 0; md[1] = 0; mw[0] = 0; mw[1] = 0; mwv = 0; mtd = 0; tx_left = 0;

      // Reset state
      cyc(1'b1, 2'b00, 1'b0, 4'h0);
      chk("reset.word_valid", 32'(m_wv), 0);

      // Deserialise 1,0,0,1 with both bit orders
      cyc(1'b0, 2'b01, 1'b1, 4'h0);
      chk("des.msb.step1", 32'(m_data), 32'h1);
      chk("des.lsb.step1", 32'(l_data), 32'h8);
      cyc(1'b0, 2'b01, 1'b0, 4'h0);
      chk("des.msb.step2", 32'(m_data), 32'h2);
      chk("des.lsb.step2", 32'(l_data), 32'h4);
      cyc(1'b0, 2'b01, 1'b0, 4'h0);
      chk("des.msb.step3", 32'(m_data), 32'h4);
      chk("des.lsb.step3", 32'(l_data), 32'h2);
      cyc(1'b0, 2'b01, 1'b1, 4'h0);
      chk("des.msb.word",  32'(m_word), 32'h9);
      chk("des.lsb.word",  32'(l_word), 32'h9);
      chk("des.wv",        32'(m_wv),   1);
      chk("des.bit_cnt",   32'(m_bc),   0);

      // Back-to-back second frame 0,1,0,1
      cyc(1'b0, 2'b01, 1'b0, 4'h0);
      chk("b2b.wv_drop", 32'(m_wv), 0);
      cyc(1'b0, 2'b01, 1'b1, 4'h0);
      cyc(1'b0, 2'b01, 1'b0, 4'h0);
      cyc(1'b0, 2'b01, 1'b1, 4'h0);
      chk("b2b.msb.word", 32'(m_word), 32'h5);
      chk("b2b.lsb.word", 32'(l_word), 32'hA);
      chk("b2b.wv",       32'(m_wv),   1);

      // Load 1011 and serialise MSB-first
      cyc(1'b0, 2'b10, 1'b0, 4'hB);
      chk("ser.bit0", 32'(m_so), 1);
      cyc(1'b0, 2'b11, 1'b0, 4'h0);
      chk("ser.bit1", 32'(m_so), 0);
      cyc(1'b0, 2'b11, 1'b0, 4'h0);
      chk("ser.bit2", 32'(m_so), 1);
      cyc(1'b0, 2'b11, 1'b0, 4'h0);
      chk("ser.bit3", 32'(m_so), 1);
      chk("ser.no_early_done", 32'(m_td), 0);
      cyc(1'b0, 2'b11, 1'b0, 4'h0);
      chk("ser.tx_done", 32'(m_td),   1);
      chk("ser.empty",   32'(m_data), 0);
      cyc(1'b0, 2'b11, 1'b0, 4'h0);
      chk("ser.no_second_done", 32'(m_td), 0);

      // Pause a frame with hold: 1,1, hold x3, 0,1
      cyc(1'b1, 2'b00, 1'b0, 4'h0);
      cyc(1'b0, 2'b01, 1'b1, 4'h0);
      cyc(1'b0, 2'b01, 1'b1, 4'h0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 2'b00, 1'b1, 4'h0);
         chk("hold.no_wv",   32'(m_wv), 0);
         chk("hold.bit_cnt", 32'(m_bc), 2);
      end
      cyc(1'b0, 2'b01, 1'b0, 4'h0);
      cyc(1'b0, 2'b01, 1'b1, 4'h0);
      chk("hold.word", 32'(m_word), 32'hD);
      chk("hold.wv",   32'(m_wv),   1);

      // Abort a partial frame with reset
      for (int i = 0; i < 3; i++) cyc(1'b0, 2'b01, 1'b1, 4'h0);
      cyc(1'b1, 2'b01, 1'b1, 4'h0);
      chk("abort_rst.data", 32'(m_data), 0);
      chk("abort_rst.word", 32'(m_word), 0);
      chk("abort_rst.cnt",  32'(m_bc),   0);

      // Abort a partial frame with load; previous word must survive
      for (int i = 0; i < 4; i++) cyc(1'b0, 2'b01, (i != 1), 4'h0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 2'b01, 1'b1, 4'h0);
      cyc(1'b0, 2'b10, 1'b1, 4'h6);
      chk("abort_ld.cnt",  32'(m_bc),   0);
      chk("abort_ld.word", 32'(m_word), 32'hB);
      chk("abort_ld.wv",   32'(m_wv),   0);
      chk("abort_ld.data", 32'(m_data), 32'h6);

      // Randomised traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         pr = W'($urandom);
         cyc(($urandom_range(0, 39) == 0), 2'($urandom), 1'($urandom), pr);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
